// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: ALU_control codes (also used by
// the ALU control unit) and the multiplier state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add signed multiplier: magnitudes are multiplied over
// WIDTH cycles, then the sign is applied in the one-cycle DONE state.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_e               state_reg;
    logic [CNT_W-1:0]         count_reg;
    logic [WIDTH-1:0]         mcand_reg;
    logic [2*WIDTH-1:0]       prod_reg;
    logic                     sign_reg;

    logic [WIDTH-1:0]         abs_a;
    logic [WIDTH-1:0]         abs_b;
    logic [WIDTH:0]           partial_sum;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // Upper half accumulates; the multiplier sits in the lower half and is
    // consumed LSB-first as the whole register shifts right.
    assign partial_sum = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                       + {1'b0, mcand_reg & {WIDTH{prod_reg[0]}}};

    assign product = sign_reg ? -prod_reg : prod_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            mcand_reg <= '0;
            prod_reg  <= '0;
            sign_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg <= abs_a;
                        prod_reg  <= {{WIDTH{1'b0}}, abs_b};
                        sign_reg  <= a[WIDTH-1] ^ b[WIDTH-1];
                        count_reg <= '0;
                        state_reg <= MUL;
                    end
                end
                MUL: begin
                    prod_reg  <= {partial_sum, prod_reg[WIDTH-1:1]};
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CNT_W'(WIDTH - 1))
                        state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops plus an iterative signed multiply into HI/LO.
// Optional signed add/sub overflow flag is built when ALU_EXEC_OVF_EN is defined.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [3:0]         ALU_control,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               overflow
);

    logic               accept;
    logic               is_mul;
    logic               mul_start;
    logic               alu_accept;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic               slt_bit;
    logic [WIDTH-1:0]   alu_res;

    logic               out_valid_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    assign sum     = op_a + op_b;
    assign diff    = op_a - op_b;
    assign slt_bit = ($signed(op_a) < $signed(op_b));

    // Unknown codes (including an undriven jr code) fall to the default arm,
    // producing result 0 with zero set.
    always_comb begin
        alu_res = '0;
        is_mul  = 1'b0;
        case (ALU_control)
            ALU_ADD: alu_res = sum;
            ALU_SUB: alu_res = diff;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_NOR: alu_res = ~(op_a | op_b);
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_SLL: alu_res = op_b << shamt;
            ALU_MUL: is_mul  = 1'b1;
            default: alu_res = '0;
        endcase
    end

    assign accept     = in_valid & ~mul_busy;
    assign mul_start  = accept & is_mul;
    assign alu_accept = accept & ~is_mul;
    assign busy       = mul_busy;

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            if (mul_done) begin
                hi_reg        <= mul_product[2*WIDTH-1:WIDTH];
                lo_reg        <= mul_product[WIDTH-1:0];
                result_reg    <= mul_product[WIDTH-1:0];
                zero_reg      <= (mul_product[WIDTH-1:0] == '0);
                out_valid_reg <= 1'b1;
            end else if (alu_accept) begin
                result_reg    <= alu_res;
                zero_reg      <= (alu_res == '0);
                out_valid_reg <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;

`ifdef ALU_EXEC_OVF_EN
    logic ovf_next;
    logic overflow_reg;

    always_comb begin
        ovf_next = 1'b0;
        case (ALU_control)
            ALU_ADD: ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            ALU_SUB: ovf_next = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            default: ovf_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow_reg <= 1'b0;
        else if (mul_done)
            overflow_reg <= 1'b0;
        else if (alu_accept)
            overflow_reg <= ovf_next;
    end

    assign overflow = overflow_reg;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expectations, a negedge
// monitor pops and compares on every out_valid. Honours ALU_EXEC_OVF_EN.
module tb_alu_exec_unit;
    import alu_pkg::*;

`ifdef ALU_EXEC_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  ALU_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        busy;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        overflow;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .ALU_control (ALU_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .shamt       (shamt),
        .busy        (busy),
        .out_valid   (out_valid),
        .result      (result),
        .zero        (zero),
        .hi          (hi),
        .lo          (lo),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        zero;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid cycle consumes exactly one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                $display("txn %-12s cyc=%0d result=0x%08h zero=%0b hi=0x%08h lo=0x%08h ovf=%0b",
                         e.name, cyc, result, zero, hi, lo, overflow);
                check({e.name, "_cycle"},  64'(cyc),      64'(e.cyc));
                check({e.name, "_result"}, 64'(result),   64'(e.res));
                check({e.name, "_zero"},   64'(zero),     64'(e.zero));
                check({e.name, "_hi"},     64'(hi),       64'(e.hi));
                check({e.name, "_lo"},     64'(lo),       64'(e.lo));
                check({e.name, "_ovf"},    64'(overflow), 64'(e.ovf));
            end
        end
    end

    // Drive an op at a negedge, hold it until busy is low, then drop in_valid
    // after the accepting edge. exp_val is the result, or {hi,lo} for mult.
    task automatic issue(input string name, input logic [3:0] code,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic [63:0] exp_val, input logic eovf, input bit push);
        exp_t e;
        int   waited;
        @(negedge clk);
        in_valid    = 1'b1;
        ALU_control = code;
        op_a        = a;
        op_b        = b;
        shamt       = sh;
        waited      = 0;
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept_timeout: got busy=1 after %0d cycles, expected 0", name, waited);
        end
        if (code === ALU_MUL) begin
            if (push) begin
                model_hi = exp_val[63:32];
                model_lo = exp_val[31:0];
            end
            e.cyc = cyc + 1 + 33;
        end else begin
            e.cyc = cyc + 1;
        end
        e.name = name;
        e.res  = exp_val[31:0];
        e.zero = (exp_val[31:0] == 32'd0);
        e.hi   = model_hi;
        e.lo   = model_lo;
        e.ovf  = eovf & OVF_ON;
        if (push) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_result"},    64'(result),    64'd0);
        check({tag, "_zero"},      64'(zero),      64'd0);
        check({tag, "_hi"},        64'(hi),        64'd0);
        check({tag, "_lo"},        64'(lo),        64'd0);
        check({tag, "_overflow"},  64'(overflow),  64'd0);
    endtask

    initial begin
        int busy_cycles;
        int t;
        logic [3:0] xcode;
        reset       = 1'b1;
        in_valid    = 1'b0;
        ALU_control = 4'b0000;
        op_a        = '0;
        op_b        = '0;
        shamt       = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        issue("add_ovf",  ALU_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 64'h80000000, 1'b1, 1'b1);
        issue("sub_zero", ALU_SUB, 32'd5, 32'd5, 5'd0, 64'h0, 1'b0, 1'b1);
        issue("slt",      ALU_SLT, 32'hFFFFFFFF, 32'h1, 5'd0, 64'h1, 1'b0, 1'b1);
        issue("sll31",    ALU_SLL, 32'h0, 32'h1, 5'd31, 64'h80000000, 1'b0, 1'b1);
        issue("and",      ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 64'hF000F000, 1'b0, 1'b1);
        issue("or",       ALU_OR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 64'hFFF0FFF0, 1'b0, 1'b1);
        issue("nor",      ALU_NOR, 32'h0, 32'h0, 5'd0, 64'hFFFFFFFF, 1'b0, 1'b1);
        issue("sub_ovf",  ALU_SUB, 32'h80000000, 32'h1, 5'd0, 64'h7FFFFFFF, 1'b1, 1'b1);

        // -2 x 3, with busy-duration measurement
        issue("mul_m2x3", ALU_MUL, 32'hFFFFFFFE, 32'd3, 5'd0, 64'hFFFFFFFF_FFFFFFFA, 1'b0, 1'b1);
        busy_cycles = 0;
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("mul_busy_cycles", 64'(busy_cycles), 64'd33);

        issue("mul_x0",     ALU_MUL, 32'h00001234, 32'h0, 5'd0, 64'h0, 1'b0, 1'b1);
        issue("mul_minmin", ALU_MUL, 32'h80000000, 32'h80000000, 5'd0, 64'h40000000_00000000, 1'b0, 1'b1);
        issue("mul_minx1",  ALU_MUL, 32'h80000000, 32'h1, 5'd0, 64'hFFFFFFFF_80000000, 1'b0, 1'b1);
        // Held behind busy: must land only after the mult completes, keeping hi/lo
        issue("add_held",   ALU_ADD, 32'd2, 32'd3, 5'd0, 64'd5, 1'b0, 1'b1);

        issue("code_1010", 4'b1010, 32'h12345678, 32'h9ABCDEF0, 5'd3, 64'h0, 1'b0, 1'b1);
        xcode = 4'bxxxx;
        issue("code_x",    xcode, 32'h0000000F, 32'h000000F0, 5'd0, 64'h0, 1'b0, 1'b1);
        issue("add_1p1",   ALU_ADD, 32'd1, 32'd1, 5'd0, 64'd2, 1'b0, 1'b1);

        // Abort a mult around iteration 10 with an asynchronous reset
        issue("mul_abort", ALU_MUL, 32'd7, 32'd9, 5'd0, 64'd63, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue("add_2p2", ALU_ADD, 32'd2, 32'd2, 5'd0, 64'd4, 1'b0, 1'b1);

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU. Consumes the 4-bit ALU_control code from the ALU control unit, plus register operands, and produces a registered result and zero flag.
- Single-cycle ops (add/sub/and/or/nor/slt/sll) have latency 1.
- mult runs on an iterative radix-2 shift-add engine and updates HI/LO. The unit raises busy so the pipeline control stalls the issue stage.

Parameters:
- WIDTH, 32, operand/result width; mult takes WIDTH iterations.
- SHAMT_W, 5, shift-amount width (log2 WIDTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation presented this cycle
- ALU_control  in  4  operation code from ALU control unit
- op_a  in  WIDTH  rs operand
- op_b  in  WIDTH  rt / sign-extended immediate
- shamt  in  SHAMT_W  shift amount for sll
- busy  out  1  multiply in progress; new ops not accepted
- out_valid  out  1  one-cycle pulse: result/zero valid
- result  out  WIDTH  registered result
- zero  out  1  result == 0 (registered with result)
- hi  out  WIDTH  upper product register
- lo  out  WIDTH  lower product register
- overflow  out  1  signed add/sub overflow (see Optional Feature)

Behaviour:
- Reset is async, active-high. While asserted: busy=0, out_valid=0, result=0, zero=0, hi=0, lo=0, overflow=0, state=IDLE, counter=0.
- Accept rule: an op is accepted on a rising edge when in_valid=1 and busy=0. in_valid while busy=1 is ignored; upstream holds the op.
- Codes accepted at edge N; result, zero and out_valid=1 appear after edge N (visible cycle N+1):
  - 0010 add: a+b mod 2^WIDTH
  - 0110 sub: a-b mod 2^WIDTH
  - 0000 and, 0001 or
  - 1100 nor: ~(a|b)
  - 0111 slt: signed a<b gives 1, else 0
  - 1111 sll: b<<shamt, zero-filled
- Any other code (including x/z from jr): result=0, zero=1, out_valid=1; hi/lo unchanged.
- out_valid is a single-cycle pulse. result and zero hold until the next completion.
- 1001 mult (signed WIDTH x WIDTH gives 2*WIDTH):
  - On accept: state IDLE->MUL, busy=1 from the next cycle. Latch |a|, |b|, sign = a[MSB]^b[MSB]. Clear the accumulator. counter=0.
  - MUL: one partial-product add/shift per cycle. counter increments; WIDTH cycles total.
  - When counter==WIDTH-1: state->DONE.
  - DONE (1 cycle): two's-complement the product if sign=1. {hi,lo}=product, result=lo, zero=(lo==0), out_valid=1, busy=0. state->IDLE.
  - Total: accept at edge N, out_valid visible after edge N+WIDTH+1 (33 for WIDTH=32). busy is high for WIDTH+1 cycles.
  - A new op may be accepted on the edge where DONE completes only if busy already reads 0. busy is registered and drops in the DONE cycle's next state, so the earliest new accept is the edge after out_valid.
- Boundaries:
  - -2^31 x -2^31 gives hi=0x40000000, lo=0.
  - -2^31 x 1 gives hi=0xFFFFFFFF, lo=0x80000000.
  - x0 gives all zeros.
- Reset mid-mult: the op is aborted, all outputs return to reset values, and there is no out_valid.
- Non-mult ops never modify hi/lo.

Optional Feature:
- Macro ALU_EXEC_OVF_EN.
- Defined: overflow registered with result. For add it is set when both operand signs are equal and the result sign differs. For sub it is set when operand signs differ and the result sign differs from a. It is 0 for all other ops. It is valid with out_valid and holds like result.
- Undefined: overflow is tied to 0 and the detection logic is not built.

Decomposition:
- Shared package alu_pkg:
  - ALU_control code constants (ALU_AND=4'b0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_MUL=1001, ALU_NOR=1100, ALU_SLL=1111), shared with the ALU control unit.
  - State encoding IDLE/MUL/DONE.
- One sub-module: seq_multiplier, holding the shift-add engine, counter and sign fix, with a start/done interface.
- Single-cycle datapath and output registers stay in alu_exec_unit.

Test Plan:
- add 0x7FFFFFFF+1 -> result=0x80000000, zero=0, out_valid one cycle after accept; overflow=1 with ALU_EXEC_OVF_EN, 0 without.
- sub 5-5, then slt a=0xFFFFFFFF b=1 -> result=0/zero=1; then result=1/zero=0. sll b=0x1 shamt=31 -> 0x80000000.
- mult a=0xFFFFFFFE (-2) b=3 -> busy high 33 cycles, out_valid at edge N+33, hi=0xFFFFFFFF, lo=0xFFFFFFFA, result=lo.
- in_valid with add held during mult busy -> not accepted until busy=0; hi/lo from mult preserved after the add completes.
- reset asserted at mult iteration 10 -> immediate busy=0, hi=lo=result=0, no out_valid; next add 2+2 -> result=4 one cycle after accept.
- code 4'bxxxx (jr) and 4'b1010 -> result=0, zero=1, out_valid=1, hi/lo unchanged.
